// File: rtl/rocketcpu_uart_fifo.sv
// Wishbone-slave UART: TX/RX byte FIFOs, runtime baud divider, sticky error
// status with write-1-to-clear, and a maskable registered level interrupt.

module rocketcpu_uart_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  output logic [7:0]             data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   push_ok_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_FULL);
  // A push into a full buffer still lands when a pop frees the slot this cycle.
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign push_ok_o = do_push;
  assign data_o    = mem_q[rd_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_ONE;
    end
  end
endmodule

module rocketcpu_uart_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 104,
  parameter int MIN_DIV     = 4
) (
  input  logic        i_wb_clk,
  input  logic        resetn,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq,
  output logic        ser_tx,
  input  logic        ser_rx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] DEF_DIV_W = 32'(DEFAULT_DIV);
  localparam logic [31:0] MIN_DIV_W = 32'(MIN_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic        ack_q;
  logic [31:0] rdt_q, rdt_d;
  logic        irq_q, irq_d;
  logic [31:0] div_q, div_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, ferr_q, ferr_d;
  logic        acc, wr, rd;
  logic [31:0] status;
  logic        unused_sel;

  logic          tx_push, tx_pop, tx_push_ok, tx_full, tx_empty, tx_busy;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_push_ok, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

  state_e      tx_state_q, tx_state_d;
  logic [31:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_ser_q, tx_ser_d, tx_load, tx_tick;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  state_e      rx_state_q, rx_state_d;
  logic [31:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_target;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_tick, rx_ferr_set;

  assign unused_sel = ^i_wb_sel[3:1];

  // Side effects fire only on the cycle the ack is being raised.
  assign acc     = i_wb_cyc & ~ack_q;
  assign wr      = acc & i_wb_we;
  assign rd      = acc & ~i_wb_we;
  assign tx_push = wr & (i_wb_adr == 2'd0) & i_wb_sel[0];
  assign rx_pop  = rd & (i_wb_adr == 2'd0);
  assign tx_busy = (tx_state_q != S_IDLE);

  assign status = {8'h00, 8'(tx_count), 8'(rx_count), tx_busy, ferr_q, rx_ovf_q,
                   tx_ovf_q, rx_full, ~rx_empty, tx_empty, tx_full};

  rocketcpu_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(i_wb_clk), .rst_ni(resetn), .push_i(tx_push), .data_i(i_wb_dat[7:0]),
    .pop_i(tx_pop), .data_o(tx_head), .count_o(tx_count), .full_o(tx_full),
    .empty_o(tx_empty), .push_ok_o(tx_push_ok)
  );

  rocketcpu_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(i_wb_clk), .rst_ni(resetn), .push_i(rx_push), .data_i(rx_sh_q),
    .pop_i(rx_pop), .data_o(rx_head), .count_o(rx_count), .full_o(rx_full),
    .empty_o(rx_empty), .push_ok_o(rx_push_ok)
  );

  always_comb begin
    div_d    = div_q;
    ctrl_d   = ctrl_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    ferr_d   = ferr_q;
    rdt_d    = '0;
    if (wr) begin
      case (i_wb_adr)
        2'd1: begin
          if (i_wb_dat[4]) tx_ovf_d = 1'b0;
          if (i_wb_dat[5]) rx_ovf_d = 1'b0;
          if (i_wb_dat[6]) ferr_d   = 1'b0;
        end
        2'd2:    div_d  = (i_wb_dat < MIN_DIV_W) ? MIN_DIV_W : i_wb_dat;
        2'd3:    ctrl_d = i_wb_dat[1:0];
        default: ;
      endcase
    end
    if (rd) begin
      case (i_wb_adr)
        2'd0:    rdt_d = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_head};
        2'd1:    rdt_d = status;
        2'd2:    rdt_d = div_q;
        default: rdt_d = {30'h0, ctrl_q};
      endcase
    end
    // New error events win over a simultaneous clear.
    if (tx_push && !tx_push_ok) tx_ovf_d = 1'b1;
    if (rx_push && !rx_push_ok) rx_ovf_d = 1'b1;
    if (rx_ferr_set)            ferr_d   = 1'b1;
    irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & ~tx_busy);
  end

  always_ff @(posedge i_wb_clk or negedge resetn) begin
    if (!resetn) begin
      ack_q    <= 1'b0;
      rdt_q    <= '0;
      irq_q    <= 1'b0;
      div_q    <= DEF_DIV_W;
      ctrl_q   <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ack_q    <= i_wb_cyc & ~ack_q;
      rdt_q    <= rdt_d;
      irq_q    <= irq_d;
      div_q    <= div_d;
      ctrl_q   <= ctrl_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      ferr_q   <= ferr_d;
    end
  end

  // Transmitter: a byte waiting at the end of STOP starts immediately, no idle gap.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 32'd1;
    tx_div_d   = tx_div_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_ser_d   = tx_ser_q;
    tx_load    = 1'b0;
    tx_tick    = (tx_cnt_q == tx_div_q - 32'd1);
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_ser_d = 1'b1;
        tx_load  = ~tx_empty;
      end
      S_START: if (tx_tick) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_div_d   = div_q;
        tx_ser_d   = tx_sh_q[0];
        tx_bit_d   = '0;
      end
      S_DATA: if (tx_tick) begin
        tx_cnt_d = '0;
        tx_div_d = div_q;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP;
          tx_ser_d   = 1'b1;
        end else begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_ser_d = tx_sh_q[1];
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      S_STOP: if (tx_tick) begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
        tx_ser_d   = 1'b1;
        tx_load    = ~tx_empty;
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_load) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      tx_div_d   = div_q;
      tx_sh_d    = tx_head;
      tx_ser_d   = 1'b0;
    end
  end

  assign tx_pop = tx_load;

  always_ff @(posedge i_wb_clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEF_DIV_W;
      tx_bit_q   <= '0;
      tx_ser_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_ser_q   <= tx_ser_d;
    end
  end

  // Receiver: start is confirmed at half a bit, later samples land mid-bit.
  assign rx_target = (rx_state_q == S_START) ? {1'b0, rx_div_q[31:1]} : rx_div_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 32'd1;
    rx_div_d    = rx_div_q;
    rx_sh_d     = rx_sh_q;
    rx_bit_d    = rx_bit_q;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    rx_tick     = (rx_cnt_q == rx_target - 32'd1);
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_div_d   = div_q;
        end
      end
      S_START: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_div_d   = div_q;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tick) begin
        rx_cnt_d = '0;
        rx_div_d = div_q;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      S_STOP: if (rx_tick) begin
        rx_cnt_d    = '0;
        rx_state_d  = S_IDLE;
        rx_push     = rx_s2_q;
        rx_ferr_set = ~rx_s2_q;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEF_DIV_W;
      rx_bit_q   <= '0;
    end else begin
      rx_s1_q    <= ser_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = irq_q;
  assign ser_tx   = tx_ser_q;
endmodule

// File: tb/tb_rocketcpu_uart_fifo.sv
// Directed bench for rocketcpu_uart_fifo (FIFO_DEPTH=4): bus access, TX framing,
// loopback RX with overflow, TX overflow, frame error, glitch, interrupt, reset.

module tb_rocketcpu_uart_fifo;
  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;
  logic        ser_tx;
  logic        ser_rx;
  logic        lb = 1'b0;
  logic        rx_drv = 1'b1;

  int n_pass = 0;
  int n_chk  = 0;
  int cycles = 0;
  int mon_div = 8;
  logic [8:0]  mon_q[$];
  int          mon_t[$];
  logic        irq_at_ack;
  logic [31:0] r;

  assign ser_rx = lb ? ser_tx : rx_drv;

  rocketcpu_uart_fifo #(.FIFO_DEPTH(4), .DEFAULT_DIV(104), .MIN_DIV(4)) dut (
    .i_wb_clk(clk), .resetn(resetn), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack), .o_irq(irq),
    .ser_tx(ser_tx), .ser_rx(ser_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  // Serial decoder on ser_tx: records start-edge cycle and {stop, byte}.
  initial begin : monitor
    logic [7:0] b;
    logic       s;
    forever begin
      @(negedge ser_tx);
      mon_t.push_back(cycles);
      repeat (mon_div / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (mon_div) @(posedge clk);
        #1 b[i] = ser_tx;
      end
      repeat (mon_div) @(posedge clk);
      #1 s = ser_tx;
      mon_q.push_back({s, b});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] q);
    cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk); #1;
    chk("ack", 32'(ack), 32'h1);
    q = rdt;
    irq_at_ack = irq;
    cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    bus(1'b0, a, 32'h0, 4'hF, q);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
    rx_drv = 1'b0;
    repeat (d) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (d) @(posedge clk); #1;
    end
    rx_drv = stop;
    repeat (d) @(posedge clk); #1;
    rx_drv = 1'b1;
  endtask

  initial begin
    int k;
    resetn = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Reset state and basic reads
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdt", rdt, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ser_tx", 32'(ser_tx), 32'h1);
    rd(2'd1, r); chk("rst_status", r, 32'h0000_0002);
    rd(2'd2, r); chk("rst_div", r, 32'd104);
    rd(2'd3, r); chk("rst_ctrl", r, 32'h0);
    rd(2'd0, r); chk("data_empty", r, 32'hFFFF_FFFF);
    chk("rdt_idle", rdt, 32'h0);

    // Back-to-back transmit at 8 clocks per bit
    wr(2'd2, 32'd8);
    rd(2'd2, r); chk("div8", r, 32'd8);
    bus(1'b1, 2'd0, 32'h0000_00FF, 4'hE, r);
    rd(2'd1, r); chk("sel0_nopush", r, 32'h0000_0002);
    mon_q.delete(); mon_t.delete(); mon_div = 8;
    wr(2'd0, 32'h55);
    wr(2'd0, 32'hA3);
    repeat (200) @(posedge clk); #1;
    chk("tx_nbytes", 32'(mon_q.size()), 32'd2);
    if (mon_q.size() >= 2) begin
      chk("tx_byte0", 32'(mon_q[0]), 32'h155);
      chk("tx_byte1", 32'(mon_q[1]), 32'h1A3);
      chk("tx_gap", 32'(mon_t[1] - mon_t[0]), 32'd80);
    end
    rd(2'd1, r); chk("tx_done_status", r, 32'h0000_0002);

    // Loopback: five bytes into a four-deep RX FIFO
    lb = 1'b1;
    for (int i = 1; i <= 5; i++) wr(2'd0, 32'(i));
    repeat (500) @(posedge clk); #1;
    rd(2'd1, r); chk("rx_full_status", r, 32'h0000_042E);
    for (int i = 1; i <= 4; i++) begin
      rd(2'd0, r); chk("rx_data", r, 32'(i));
    end
    rd(2'd0, r); chk("rx_drained", r, 32'hFFFF_FFFF);
    rd(2'd1, r); chk("rx_ovf_kept", r, 32'h0000_0022);
    wr(2'd1, 32'h10);
    rd(2'd1, r); chk("w1c_wrong_bit", r, 32'h0000_0022);
    wr(2'd1, 32'h20);
    rd(2'd1, r); chk("w1c_rx_ovf", r, 32'h0000_0002);
    lb = 1'b0;

    // TX overflow: one byte in flight, four queued, sixth dropped
    wr(2'd2, 32'd100);
    mon_q.delete(); mon_t.delete(); mon_div = 100;
    for (int i = 0; i < 6; i++) wr(2'd0, 32'h11 + 32'(i));
    rd(2'd1, r); chk("tx_ovf_status", r, 32'h0004_0091);
    repeat (5100) @(posedge clk); #1;
    chk("ovf_nbytes", 32'(mon_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < mon_q.size()) chk("ovf_byte", 32'(mon_q[i]), 32'h111 + 32'(i));
    end
    rd(2'd1, r); chk("tx_ovf_sticky", r, 32'h0000_0012);
    wr(2'd1, 32'h10);
    rd(2'd1, r); chk("w1c_tx_ovf", r, 32'h0000_0002);

    // Frame error, then a short glitch, then a good frame
    wr(2'd2, 32'd8);
    send_frame(8'h3C, 1'b0, 8);
    repeat (10) @(posedge clk); #1;
    rd(2'd1, r); chk("frame_err", r, 32'h0000_0042);
    wr(2'd1, 32'h40);
    wr(2'd2, 32'd16);
    rx_drv = 1'b0;
    repeat (2) @(posedge clk); #1;
    rx_drv = 1'b1;
    repeat (40) @(posedge clk); #1;
    rd(2'd1, r); chk("glitch_ignored", r, 32'h0000_0002);
    send_frame(8'h5A, 1'b1, 16);
    repeat (4) @(posedge clk); #1;
    rd(2'd0, r); chk("rx_after_glitch", r, 32'h5A);

    // Interrupt behaviour and divider clamp
    wr(2'd2, 32'd8);
    wr(2'd3, 32'h1);
    rd(2'd3, r); chk("ctrl_rb", r, 32'h1);
    chk("irq_idle", 32'(irq), 32'h0);
    send_frame(8'h7E, 1'b1, 8);
    k = 0;
    while (irq !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("irq_rise", 32'(irq), 32'h1);
    rd(2'd0, r); chk("irq_data", r, 32'h7E);
    chk("irq_at_pop", 32'(irq_at_ack), 32'h1);
    chk("irq_fall", 32'(irq), 32'h0);
    wr(2'd3, 32'h2);
    chk("irq_tx_empty", 32'(irq), 32'h1);
    wr(2'd3, 32'h0);
    wr(2'd2, 32'd2);
    rd(2'd2, r); chk("div_clamp", r, 32'd4);

    // Reset mid-frame
    wr(2'd2, 32'd100);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    repeat (40) @(posedge clk); #1;
    chk("mid_frame_low", 32'(ser_tx), 32'h0);
    #2 resetn = 1'b0;
    #1 chk("async_ser_tx", 32'(ser_tx), 32'h1);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    rd(2'd1, r); chk("post_rst_status", r, 32'h0000_0002);
    rd(2'd2, r); chk("post_rst_div", r, 32'd104);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
